srcopr_wakeup_buf: RTL

- Parametrised operand-wakeup buffer: successor to the single-operand combinational forwarding unit.
- Holds up to DEPTH dispatched instructions, each with two source operands. An operand is either a value, or an RRF tag that is still pending.
- Snoops NCH writeback broadcast channels every cycle and captures results into pending operands. Issues the lowest-index fully-ready entry through a valid/ready handshake.
- Sits between dispatch and one execution unit, as a reservation station.

---
 rtl/srcopr_wakeup_buf.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/srcopr_wakeup_buf.sv
// srcopr_wakeup_buf: operand-wakeup reservation station.
// Holds up to DEPTH instructions with two source operands each. Pending
// operands snoop NCH writeback channels. The lowest-index fully-ready entry
// is presented through a valid/ready issue port.
module srcopr_wakeup_buf #(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned TAG_W  = 6,
  parameter  int unsigned NCH    = 3,
  parameter  int unsigned DEPTH  = 8,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_alloc_vld,
  output logic                  o_alloc_rdy,
  input  logic                  i_alloc_src1_vld,
  input  logic [DATA_W-1:0]     i_alloc_src1,
  input  logic                  i_alloc_src2_vld,
  input  logic [DATA_W-1:0]     i_alloc_src2,
  input  logic [TAG_W-1:0]      i_alloc_dst_tag,
  input  logic [NCH-1:0]        i_wb_vld,
  input  logic [NCH*TAG_W-1:0]  i_wb_tag,
  input  logic [NCH*DATA_W-1:0] i_wb_data,
  output logic                  o_iss_vld,
  input  logic                  i_iss_rdy,
  output logic [DATA_W-1:0]     o_iss_src1,
  output logic [DATA_W-1:0]     o_iss_src2,
  output logic [TAG_W-1:0]      o_iss_dst_tag,
  output logic [CNT_W-1:0]      o_count,
  output logic                  o_empty
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  // Entry state
  logic [DEPTH-1:0]  r_vld;
  logic [DEPTH-1:0]  r_s1_rdy;
  logic [DEPTH-1:0]  r_s2_rdy;
  logic [DATA_W-1:0] r_s1    [DEPTH];
  logic [DATA_W-1:0] r_s2    [DEPTH];
  logic [TAG_W-1:0]  r_dst   [DEPTH];
  logic [CNT_W-1:0]  r_count;

  // Post-wakeup view of every stored operand and of the incoming operands
  logic [DEPTH-1:0]  w_s1_rdy_nxt;
  logic [DEPTH-1:0]  w_s2_rdy_nxt;
  logic [DATA_W-1:0] w_s1_nxt [DEPTH];
  logic [DATA_W-1:0] w_s2_nxt [DEPTH];
  logic              w_a1_rdy;
  logic              w_a2_rdy;
  logic [DATA_W-1:0] w_a1;
  logic [DATA_W-1:0] w_a2;

  logic              w_iss_any;
  logic [IDX_W-1:0]  w_iss_idx;
  logic              w_free_any;
  logic [IDX_W-1:0]  w_free_idx;
  logic              w_alloc_fire;
  logic              w_iss_fire;

  // Returns {rdy, value}: a pending operand captures the lowest matching
  // channel; a ready operand passes through untouched.
  function automatic logic [DATA_W:0] f_wake(
    input logic                  rdy,
    input logic [DATA_W-1:0]     val,
    input logic [NCH-1:0]        wb_vld,
    input logic [NCH*TAG_W-1:0]  wb_tag,
    input logic [NCH*DATA_W-1:0] wb_data
  );
    logic              hit;
    logic [DATA_W-1:0] res;
    hit = rdy;
    res = val;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (!hit && wb_vld[k] && (val[TAG_W-1:0] == wb_tag[k*TAG_W +: TAG_W])) begin
        hit = 1'b1;
        res = wb_data[k*DATA_W +: DATA_W];
      end
    end
    return {hit, res};
  endfunction

  // Wakeup match for stored entries and for the operands being allocated
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      {w_s1_rdy_nxt[i], w_s1_nxt[i]} = f_wake(r_s1_rdy[i], r_s1[i], i_wb_vld, i_wb_tag, i_wb_data);
      {w_s2_rdy_nxt[i], w_s2_nxt[i]} = f_wake(r_s2_rdy[i], r_s2[i], i_wb_vld, i_wb_tag, i_wb_data);
    end
    {w_a1_rdy, w_a1} = f_wake(i_alloc_src1_vld, i_alloc_src1, i_wb_vld, i_wb_tag, i_wb_data);
    {w_a2_rdy, w_a2} = f_wake(i_alloc_src2_vld, i_alloc_src2, i_wb_vld, i_wb_tag, i_wb_data);
  end

  // Lowest-index ready entry for issue, lowest-index free entry for allocation
  always_comb begin
    w_iss_any  = 1'b0;
    w_iss_idx  = '0;
    w_free_any = 1'b0;
    w_free_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!w_iss_any && r_vld[i] && r_s1_rdy[i] && r_s2_rdy[i]) begin
        w_iss_any = 1'b1;
        w_iss_idx = IDX_W'(i);
      end
      if (!w_free_any && !r_vld[i]) begin
        w_free_any = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  assign o_alloc_rdy  = (r_count != CNT_W'(DEPTH));
  assign w_alloc_fire = i_alloc_vld && o_alloc_rdy;
  assign w_iss_fire   = w_iss_any && i_iss_rdy;

  assign o_iss_vld     = w_iss_any;
  assign o_iss_src1    = r_s1[w_iss_idx];
  assign o_iss_src2    = r_s2[w_iss_idx];
  assign o_iss_dst_tag = r_dst[w_iss_idx];
  assign o_count       = r_count;
  assign o_empty       = (r_count == '0);

  // Valid bits and occupancy; flush overrides both alloc and issue
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld   <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_vld   <= '0;
      r_count <= '0;
    end else begin
      // The free slot is always currently invalid, so it never collides
      // with the issuing slot.
      if (w_iss_fire) begin
        r_vld[w_iss_idx] <= 1'b0;
      end
      if (w_alloc_fire) begin
        r_vld[w_free_idx] <= 1'b1;
      end
      if (w_alloc_fire && !w_iss_fire) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_iss_fire && !w_alloc_fire) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Operand payload: wakeup every cycle, allocation overwrites its slot
  always_ff @(posedge i_clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (w_alloc_fire && (w_free_idx == IDX_W'(i))) begin
        r_s1_rdy[i] <= w_a1_rdy;
        r_s1[i]     <= w_a1;
        r_s2_rdy[i] <= w_a2_rdy;
        r_s2[i]     <= w_a2;
        r_dst[i]    <= i_alloc_dst_tag;
      end else begin
        r_s1_rdy[i] <= w_s1_rdy_nxt[i];
        r_s1[i]     <= w_s1_nxt[i];
        r_s2_rdy[i] <= w_s2_rdy_nxt[i];
        r_s2[i]     <= w_s2_nxt[i];
      end
    end
  end

endmodule
